// File: rtl/pixel_writer_if.sv
// Pixel-in / framebuffer-write bus for pixel_writer.
// slave = the writer itself; master = the upstream iterator plus memory side.
interface pixel_writer_if #(
   parameter int CORDW = 10,
   parameter int COLRW = 4,
   parameter int ADDRW = 19
);
   logic             oe;
   logic             in_drawing;
   logic [CORDW-1:0] in_x;
   logic [CORDW-1:0] in_y;
   logic [COLRW-1:0] in_colr;
   logic             mem_we;
   logic [ADDRW-1:0] mem_addr;
   logic [COLRW-1:0] mem_data;
   logic             mem_ready;

   modport master (
      input  oe, mem_we, mem_addr, mem_data,
      output in_drawing, in_x, in_y, in_colr, mem_ready
   );

   modport slave (
      output oe, mem_we, mem_addr, mem_data,
      input  in_drawing, in_x, in_y, in_colr, mem_ready
   );
endinterface

// File: rtl/pixel_writer.sv
// Clips incoming pixels to the visible area, converts (x,y) to a linear
// framebuffer address and queues the writes in a small FIFO toward memory.
module pixel_writer #(
   parameter int CORDW = 10,
   parameter int COLRW = 4,
   parameter int H_RES = 640,
   parameter int V_RES = 480,
   parameter int ADDRW = 19,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pixel_writer_if.slave        bus,
   output logic                 idle,
   output logic [15:0]          wr_cnt,
   output logic [15:0]          clip_cnt
);

   localparam int PTRW = $clog2(DEPTH);
   localparam int FULLW = CORDW + 32;
   localparam logic [PTRW:0] FULL = (PTRW + 1)'(DEPTH);

   logic [PTRW-1:0]  wptr;
   logic [PTRW-1:0]  rptr;
   logic [PTRW:0]    count;

   logic [ADDRW-1:0] addr_mem [DEPTH];
   logic [COLRW-1:0] colr_mem [DEPTH];

   logic             take_p0;
   logic             clip_p0;
   logic             vld_p0;
   logic             pop;
   logic [FULLW-1:0] addr_full_p0;
   logic [ADDRW-1:0] addr_p0;

   // Accept stage: oe depends only on the registered count.
   assign bus.oe  = (count < FULL);
   assign take_p0 = bus.in_drawing && bus.oe;
   assign clip_p0 = (32'(bus.in_x) >= 32'(H_RES)) || (32'(bus.in_y) >= 32'(V_RES));
   assign vld_p0  = take_p0 && !clip_p0;

   assign addr_full_p0 = FULLW'(bus.in_y) * FULLW'(H_RES) + FULLW'(bus.in_x);
   assign addr_p0      = addr_full_p0[ADDRW-1:0];

   // FIFO head drives the memory port.
   assign bus.mem_we   = (count != '0);
   assign bus.mem_addr = addr_mem[rptr];
   assign bus.mem_data = colr_mem[rptr];
   assign pop          = bus.mem_we && bus.mem_ready;

   assign idle = (count == '0) && !bus.in_drawing;

   always_ff @(posedge clk) begin
      if (vld_p0) begin
         addr_mem[wptr] <= addr_p0;
         colr_mem[wptr] <= bus.in_colr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         wr_cnt   <= '0;
         clip_cnt <= '0;
      end else begin
         if (vld_p0) wptr <= wptr + 1'b1;
         if (pop) begin
            rptr   <= rptr + 1'b1;
            wr_cnt <= wr_cnt + 16'd1;
         end
         if (take_p0 && clip_p0) clip_cnt <= clip_cnt + 16'd1;
         case ({vld_p0, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_writer.sv
// Directed and scoreboarded bench for pixel_writer (default parameters).
module tb_pixel_writer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        idle;
   logic [15:0] wr_cnt;
   logic [15:0] clip_cnt;

   int n_checks = 0;
   int n_fail = 0;

   logic [22:0] exp_q[$];
   logic [22:0] wr_exp[$];
   logic [22:0] got_q[$];
   logic [15:0] wr_m = '0;
   logic [15:0] clip_m = '0;

   pixel_writer_if #(.CORDW(10), .COLRW(4), .ADDRW(19)) bus();

   pixel_writer #(
      .CORDW(10), .COLRW(4), .H_RES(640), .V_RES(480), .ADDRW(19), .DEPTH(DEPTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .idle     (idle),
      .wr_cnt   (wr_cnt),
      .clip_cnt (clip_cnt)
   );

   always #5 clk = ~clk;

   // Record every completed write just before the edge that performs it.
   always @(negedge clk) begin
      #4;
      if (rst_n && bus.mem_we && bus.mem_ready)
         got_q.push_back({bus.mem_addr, bus.mem_data});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // One clock cycle: check outputs against the model, drive inputs, advance model.
   task automatic step(input bit d, input int x, input int y, input int c,
                       input bit r, output bit acc);
      check("oe", 32'(bus.oe), 32'(exp_q.size() < DEPTH));
      check("mem_we", 32'(bus.mem_we), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0)
         check("head", 32'({bus.mem_addr, bus.mem_data}), 32'(exp_q[0]));
      check("wr_cnt", 32'(wr_cnt), 32'(wr_m));
      check("clip_cnt", 32'(clip_cnt), 32'(clip_m));
      bus.in_drawing = d;
      bus.in_x       = 10'(x);
      bus.in_y       = 10'(y);
      bus.in_colr    = 4'(c);
      bus.mem_ready  = r;
      #1;
      check("idle", 32'(idle), 32'(exp_q.size() == 0 && !d));
      acc = d && (exp_q.size() < DEPTH);
      if (exp_q.size() != 0 && r) begin
         wr_exp.push_back(exp_q.pop_front());
         wr_m++;
      end
      if (acc) begin
         if (x >= 640 || y >= 480) clip_m++;
         else exp_q.push_back({19'(y * 640 + x), 4'(c)});
      end
      @(negedge clk);
   endtask

   task automatic verify_written(input string tag);
      check({tag, "_n"}, 32'(got_q.size()), 32'(wr_exp.size()));
      for (int i = 0; i < got_q.size() && i < wr_exp.size(); i++)
         check(tag, 32'(got_q[i]), 32'(wr_exp[i]));
      got_q.delete();
      wr_exp.delete();
   endtask

   task automatic do_reset();
      bus.in_drawing = 1'b0;
      bus.mem_ready  = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check("rst_oe", 32'(bus.oe), 32'd1);
      check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
      check("rst_clip_cnt", 32'(clip_cnt), 32'd0);
      check("rst_idle", 32'(idle), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      wr_exp.delete();
      got_q.delete();
      wr_m = '0;
      clip_m = '0;
   endtask

   initial begin
      bit acc;
      int idx;
      int cyc;
      int x, y, c;
      logic [18:0] bp_addr [6];
      bp_addr = '{19'd650, 19'd1291, 19'd1932, 19'd2573, 19'd3214, 19'd3855};

      bus.in_drawing = 1'b0;
      bus.in_x = '0;
      bus.in_y = '0;
      bus.in_colr = '0;
      bus.mem_ready = 1'b0;
      #2;
      check("init_oe", 32'(bus.oe), 32'd1);
      check("init_mem_we", 32'(bus.mem_we), 32'd0);
      check("init_idle", 32'(idle), 32'd1);
      check("init_wr_cnt", 32'(wr_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single pixel
      step(1, 3, 2, 5, 1, acc);
      check("single_we", 32'(bus.mem_we), 32'd1);
      check("single_addr", 32'(bus.mem_addr), 32'd1283);
      check("single_data", 32'(bus.mem_data), 32'd5);
      step(0, 0, 0, 0, 1, acc);
      step(0, 0, 0, 0, 0, acc);
      check("single_wr_cnt", 32'(wr_cnt), 32'd1);
      verify_written("single_seq");

      // Clipping
      do_reset();
      step(1, 640, 0, 1, 1, acc);
      step(1, 0, 480, 2, 1, acc);
      step(1, 639, 479, 3, 1, acc);
      check("clip_addr", 32'(bus.mem_addr), 32'd307199);
      check("clip_data", 32'(bus.mem_data), 32'd3);
      step(0, 0, 0, 0, 1, acc);
      step(0, 0, 0, 0, 0, acc);
      check("clip_clip_cnt", 32'(clip_cnt), 32'd2);
      check("clip_wr_cnt", 32'(wr_cnt), 32'd1);
      verify_written("clip_seq");

      // Backpressure with 6 pixels
      do_reset();
      idx = 0;
      for (int k = 0; k < 6; k++) begin
         step(1, 10 + idx, idx + 1, idx, 0, acc);
         if (acc) idx++;
      end
      check("bp_accepted", 32'(idx), 32'd4);
      check("bp_oe", 32'(bus.oe), 32'd0);
      check("bp_addr_held", 32'(bus.mem_addr), 32'd650);
      cyc = 0;
      while ((idx < 6 || exp_q.size() != 0) && cyc < 50) begin
         step(idx < 6, 10 + idx, idx + 1, idx, 1, acc);
         if (acc) idx++;
         cyc++;
      end
      check("bp_drain_timeout", 32'(cyc < 50), 32'd1);
      step(0, 0, 0, 0, 0, acc);
      check("bp_wr_cnt", 32'(wr_cnt), 32'd6);
      check("bp_n", 32'(got_q.size()), 32'd6);
      for (int i = 0; i < 6 && i < got_q.size(); i++)
         check("bp_order", 32'(got_q[i][22:4]), 32'(bp_addr[i]));
      verify_written("bp_seq");

      // Full FIFO with a simultaneous pop
      do_reset();
      for (int k = 0; k < 4; k++) step(1, k, 7, k, 0, acc);
      check("full_oe", 32'(bus.oe), 32'd0);
      step(1, 100, 100, 9, 1, acc);
      check("full_no_push", 32'(acc), 32'd0);
      check("full_oe_after_pop", 32'(bus.oe), 32'd1);
      check("full_wr_cnt", 32'(wr_cnt), 32'd1);
      for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1, acc);
      check("full_drained_wr_cnt", 32'(wr_cnt), 32'd4);
      verify_written("full_seq");

      // Reset with three entries queued
      do_reset();
      for (int k = 0; k < 3; k++) step(1, 20 + k, 5, k, 0, acc);
      check("mid_queued_we", 32'(bus.mem_we), 32'd1);
      do_reset();
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, acc);
      check("mid_after_we", 32'(bus.mem_we), 32'd0);
      check("mid_after_wr_cnt", 32'(wr_cnt), 32'd0);
      verify_written("mid_seq");

      // 1000-pixel stream, every tenth clipped, random mem_ready
      do_reset();
      cyc = 0;
      for (int i = 0; i < 1000; i++) begin
         x = int'($urandom_range(0, 639));
         y = int'($urandom_range(0, 479));
         c = int'($urandom_range(0, 15));
         if (i % 10 == 0) begin
            if (i % 20 == 0) x = int'($urandom_range(640, 1023));
            else             y = int'($urandom_range(480, 1023));
         end
         do begin
            step(1, x, y, c, $urandom_range(0, 3) != 0, acc);
            cyc++;
         end while (!acc && cyc < 20000);
         if (cyc >= 20000) break;
      end
      check("stream_timeout", 32'(cyc < 20000), 32'd1);
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 100) begin
         step(0, 0, 0, 0, 1, acc);
         cyc++;
      end
      step(0, 0, 0, 0, 0, acc);
      check("stream_total", 32'(wr_cnt) + 32'(clip_cnt), 32'd1000);
      check("stream_clip_cnt", 32'(clip_cnt), 32'd100);
      check("stream_wr_cnt", 32'(wr_cnt), 32'd900);
      verify_written("stream_seq");

      bus.in_drawing = 1'b0;
      bus.mem_ready  = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- CORDW, 10, coordinate width.
- COLRW, 4, colour width.
- H_RES, 640, visible width in pixels.
- V_RES, 480, visible height in pixels.
- ADDRW, 19, framebuffer address width.
- DEPTH, 4, FIFO entries (power of two, >=2).
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- oe, out, 1, output enable to the upstream iterator; high = pixel accepted this cycle.
- in_drawing, in, 1, upstream pixel valid.
- in_x, in, CORDW, pixel x.
- in_y, in, CORDW, pixel y.
- in_colr, in, COLRW, pixel colour.
- mem_we, out, 1, framebuffer write request.
- mem_addr, out, ADDRW, write address.
- mem_data, out, COLRW, write colour.
- mem_ready, in, 1, framebuffer accepts the write this cycle.
- idle, out, 1, FIFO empty and no input pending.
- wr_cnt, out, 16, pixels written to memory.
- clip_cnt, out, 16, pixels discarded by clipping.
REQ-003 The block SHALL use one clock (clk), with an asynchronous, active-low reset (rst_n).

Function
REQ-004 oe SHALL equal (fifo count < DEPTH), derived from registered state only, with no combinational path from mem_ready or in_drawing.
REQ-005 An input pixel SHALL be taken on a rising edge when in_drawing && oe; otherwise inputs are ignored.
REQ-006 A taken pixel with in_x >= H_RES or in_y >= V_RES SHALL be clipped: not pushed, and clip_cnt += 1.
REQ-007 A taken, unclipped pixel SHALL be pushed with address in_y*H_RES + in_x, computed at full precision and truncated to ADDRW, together with in_colr.
REQ-008 mem_we SHALL equal (count != 0); mem_addr and mem_data SHALL present the FIFO head, held stable while mem_we && !mem_ready.
REQ-009 A pop SHALL occur on an edge where mem_we && mem_ready; wr_cnt += 1 on each pop.
REQ-010 Latency SHALL be one cycle: a pixel pushed into an empty FIFO at edge N drives mem_we=1 during cycle N+1.
REQ-011 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-012 When full, oe=0, so no push occurs, even if a pop happens the same edge; oe rises the cycle after the pop.
REQ-013 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-014 wr_cnt and clip_cnt SHALL wrap from 0xFFFF to 0.
REQ-015 idle SHALL equal (count == 0) && !in_drawing.
REQ-016 Pixels SHALL be written to memory in acceptance order, with none lost or duplicated.

Reset
REQ-017 When rst_n=0, the block SHALL immediately clear count and both pointers to 0, mem_we to 0, wr_cnt and clip_cnt to 0, and set oe to 1 and idle to !in_drawing.
REQ-018 A reset asserted mid-operation SHALL discard all FIFO contents; no mem_we SHALL occur until a new push after release.
REQ-019 FIFO storage SHALL need no reset; mem_addr and mem_data are don't-care while mem_we=0.

Verification
REQ-020 Single pixel, mem_ready=1: in (x=3, y=2, colr=5) -> next cycle mem_we=1, mem_addr=1283, mem_data=5; wr_cnt=1.
REQ-021 Clipping: inputs (640,0), (0,480), (639,479) -> only addr 307199 is written; clip_cnt=2, wr_cnt=1.
REQ-022 Backpressure: mem_ready=0 with 6 consecutive pixels -> 4 accepted, oe=0 after the 4th, mem_addr held; releasing mem_ready drains all 6 in order.
REQ-023 Full with simultaneous pop: FIFO full, mem_ready=1 for one cycle -> count=3, oe=1 the next cycle, no push on the pop edge.
REQ-024 Reset mid-stream: rst_n=0 with 3 entries queued -> mem_we=0 and wr_cnt=0 immediately, oe=1; after release, no writes until new input.
REQ-025 Stream with random mem_ready over 1000 pixels (10% clipped) -> written sequence matches the model and wr_cnt + clip_cnt = 1000.
